// File: rtl/mem_mp.sv
// Multi-ported memory with per-entry valid bits, single-cycle flush, live valid count,
// optional write-to-read bypass, optional registered read data and a write-collision flag.
module mem_mp #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int READ_PORTS   = 2,
    parameter int WRITE_PORTS  = 2,
    parameter bit BYPASS_EN    = 1'b1,
    parameter int READ_LATENCY = 0,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [READ_PORTS-1:0]               re,
    input  logic [READ_PORTS-1:0][AW-1:0]       raddr,
    output logic [READ_PORTS-1:0][WIDTH-1:0]    rdata,
    output logic [READ_PORTS-1:0]               rvalid,
    input  logic [WRITE_PORTS-1:0]              we,
    input  logic [WRITE_PORTS-1:0][AW-1:0]      waddr,
    input  logic [WRITE_PORTS-1:0][WIDTH-1:0]   wdata,
    output logic                                wconflict,
    output logic [CW-1:0]                       valid_count
);

    logic [WIDTH-1:0]                    mem [DEPTH];
    logic [DEPTH-1:0]                    valid_q;
    logic [DEPTH-1:0]                    valid_nxt;
    logic [CW-1:0]                       count_nxt;
    logic                                conflict_nxt;
    logic [WRITE_PORTS-1:0]              w_ok;
    logic [READ_PORTS-1:0][WIDTH-1:0]    rd_data;
    logic [READ_PORTS-1:0]               rd_valid;

    always_comb begin
        w_ok = '0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            w_ok[p] = we[p] && (int'(waddr[p]) < DEPTH);
        end
    end

    // Flush clears first; same-cycle writes then re-validate their entries.
    always_comb begin
        valid_nxt = flush ? '0 : valid_q;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (w_ok[p]) begin
                valid_nxt[waddr[p]] = 1'b1;
            end
        end
    end

    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_nxt = count_nxt + CW'(valid_nxt[i]);
        end
    end

    always_comb begin
        conflict_nxt = 1'b0;
        for (int a = 0; a < WRITE_PORTS; a++) begin
            for (int b = a + 1; b < WRITE_PORTS; b++) begin
                if (w_ok[a] && w_ok[b] && (waddr[a] == waddr[b])) begin
                    conflict_nxt = 1'b1;
                end
            end
        end
    end

    // Later ports are assigned last, so the highest-index port wins a collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid_q     <= '0;
            valid_count <= '0;
            wconflict   <= 1'b0;
        end else begin
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (w_ok[p]) begin
                    mem[waddr[p]] <= wdata[p];
                end
            end
            valid_q     <= valid_nxt;
            valid_count <= count_nxt;
            wconflict   <= conflict_nxt;
        end
    end

    // Reads see pre-update valid bits; flush is never bypassed, only write data is.
    always_comb begin
        rd_data  = '0;
        rd_valid = '0;
        for (int r = 0; r < READ_PORTS; r++) begin
            if (re[r] && (int'(raddr[r]) < DEPTH)) begin
                rd_data[r]  = mem[raddr[r]];
                rd_valid[r] = valid_q[raddr[r]];
                if (BYPASS_EN) begin
                    for (int p = 0; p < WRITE_PORTS; p++) begin
                        if (w_ok[p] && (waddr[p] == raddr[r])) begin
                            rd_data[r]  = wdata[p];
                            rd_valid[r] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    if (READ_LATENCY == 0) begin : g_rd_comb
        assign rdata  = rd_data;
        assign rvalid = rd_valid;
    end else begin : g_rd_reg
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rdata  <= '0;
                rvalid <= '0;
            end else begin
                rdata  <= rd_data;
                rvalid <= rd_valid;
            end
        end
    end

endmodule

// File: tb/tb_mem_mp.sv
// Bench for mem_mp: four configurations share one stimulus stream; expectations are
// queued as stimulus is driven and compared in order against sampled outputs.
module tb_mem_mp;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] act_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic [1:0]        re    = '0;
    logic [1:0][4:0]   raddr = '0;
    logic [1:0]        we    = '0;
    logic [1:0][4:0]   waddr = '0;
    logic [1:0][31:0]  wdata = '0;

    logic [1:0][31:0]  rdata_a, rdata_b, rdata_c, rdata_d;
    logic [1:0]        rvalid_a, rvalid_b, rvalid_c, rvalid_d;
    logic              wc_a, wc_b, wc_c, wc_d;
    logic [5:0]        vc_a, vc_b, vc_c;
    logic [4:0]        vc_d;

    always #5 clock = ~clock;

    // a: bypass, comb read   b: no bypass, comb read
    // c: no bypass, registered read   d: DEPTH=24, bypass, comb read
    mem_mp #(.BYPASS_EN(1'b1), .READ_LATENCY(0)) u_a (
        .clock(clock), .reset(reset), .flush(flush), .re(re), .raddr(raddr),
        .rdata(rdata_a), .rvalid(rvalid_a), .we(we), .waddr(waddr), .wdata(wdata),
        .wconflict(wc_a), .valid_count(vc_a));
    mem_mp #(.BYPASS_EN(1'b0), .READ_LATENCY(0)) u_b (
        .clock(clock), .reset(reset), .flush(flush), .re(re), .raddr(raddr),
        .rdata(rdata_b), .rvalid(rvalid_b), .we(we), .waddr(waddr), .wdata(wdata),
        .wconflict(wc_b), .valid_count(vc_b));
    mem_mp #(.BYPASS_EN(1'b0), .READ_LATENCY(1)) u_c (
        .clock(clock), .reset(reset), .flush(flush), .re(re), .raddr(raddr),
        .rdata(rdata_c), .rvalid(rvalid_c), .we(we), .waddr(waddr), .wdata(wdata),
        .wconflict(wc_c), .valid_count(vc_c));
    mem_mp #(.DEPTH(24), .BYPASS_EN(1'b1), .READ_LATENCY(0)) u_d (
        .clock(clock), .reset(reset), .flush(flush), .re(re), .raddr(raddr),
        .rdata(rdata_d), .rvalid(rvalid_d), .we(we), .waddr(waddr), .wdata(wdata),
        .wconflict(wc_d), .valid_count(vc_d));

    task automatic expect_val(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        flush = 1'b0;
        re    = '0;
        raddr = '0;
        we    = '0;
        waddr = '0;
        wdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        idle_inputs();
        re[0] = 1'b1; raddr[0] = 5'd5;
        expect_val("rst_rdata", 32'h0);
        expect_val("rst_rvalid", 32'h0);
        expect_val("rst_count", 32'h0);
        expect_val("rst_wconflict", 32'h0);
        expect_val("rst_lat1_rdata", 32'h0);
        #2;
        act_q.push_back(32'(rdata_a[0]));
        act_q.push_back(32'(rvalid_a[0]));
        act_q.push_back(32'(vc_a));
        act_q.push_back(32'(wc_a));
        act_q.push_back(32'(rdata_c[0]));
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            logic [31:0] a = (act_q.size() > 0) ? act_q.pop_front() : 32'hxxxx_xxxx;
            n_cmp++;
            if (a !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h required %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_write_bypass();
        @(negedge clock);
        idle_inputs();
        we[0] = 1'b1; waddr[0] = 5'd3; wdata[0] = 32'hA5;
        re[0] = 1'b1; raddr[0] = 5'd3;
        expect_val("byp_rdata", 32'hA5);
        expect_val("byp_rvalid", 32'h1);
        expect_val("nobyp_rdata_same", 32'h0);
        expect_val("nobyp_rvalid_same", 32'h0);
        #2;
        act_q.push_back(32'(rdata_a[0]));
        act_q.push_back(32'(rvalid_a[0]));
        act_q.push_back(32'(rdata_b[0]));
        act_q.push_back(32'(rvalid_b[0]));
        expect_val("nobyp_rdata_next", 32'hA5);
        expect_val("nobyp_rvalid_next", 32'h1);
        expect_val("wr_count_a", 32'h1);
        expect_val("wr_count_b", 32'h1);
        expect_val("wr_count_c", 32'h1);
        @(posedge clock); #1;
        act_q.push_back(32'(rdata_b[0]));
        act_q.push_back(32'(rvalid_b[0]));
        act_q.push_back(32'(vc_a));
        act_q.push_back(32'(vc_b));
        act_q.push_back(32'(vc_c));
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            logic [31:0] a = (act_q.size() > 0) ? act_q.pop_front() : 32'hxxxx_xxxx;
            n_cmp++;
            if (a !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h required %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_conflict();
        @(negedge clock);
        idle_inputs();
        we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
        wdata[0] = 32'h11; wdata[1] = 32'h22;
        re[0] = 1'b1; raddr[0] = 5'd7;
        expect_val("conf_bypass_rdata", 32'h22);
        expect_val("conf_bypass_rvalid", 32'h1);
        #2;
        act_q.push_back(32'(rdata_a[0]));
        act_q.push_back(32'(rvalid_a[0]));
        expect_val("conf_flag_a", 32'h1);
        expect_val("conf_flag_b", 32'h1);
        expect_val("conf_flag_c", 32'h1);
        expect_val("conf_count", 32'h2);
        expect_val("conf_stored", 32'h22);
        @(posedge clock); #1;
        act_q.push_back(32'(wc_a));
        act_q.push_back(32'(wc_b));
        act_q.push_back(32'(wc_c));
        act_q.push_back(32'(vc_a));
        act_q.push_back(32'(rdata_b[0]));
        @(negedge clock);
        idle_inputs();
        we = 2'b11; waddr[0] = 5'd10; waddr[1] = 5'd11;
        wdata[0] = 32'h1010; wdata[1] = 32'h1111;
        expect_val("noconf_flag", 32'h0);
        expect_val("two_port_count", 32'h4);
        @(posedge clock); #1;
        act_q.push_back(32'(wc_a));
        act_q.push_back(32'(vc_a));
        @(negedge clock);
        idle_inputs();
        re = 2'b11; raddr[0] = 5'd10; raddr[1] = 5'd11;
        expect_val("two_port_rdata0", 32'h1010);
        expect_val("two_port_rdata1", 32'h1111);
        expect_val("two_port_rvalid1", 32'h1);
        #2;
        act_q.push_back(32'(rdata_b[0]));
        act_q.push_back(32'(rdata_b[1]));
        act_q.push_back(32'(rvalid_b[1]));
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            logic [31:0] a = (act_q.size() > 0) ? act_q.pop_front() : 32'hxxxx_xxxx;
            n_cmp++;
            if (a !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h required %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            idle_inputs();
            we = 2'b11;
            waddr[0] = 5'(2 * i);     wdata[0] = 32'h100 + 32'(2 * i);
            waddr[1] = 5'(2 * i + 1); wdata[1] = 32'h101 + 32'(2 * i);
        end
        expect_val("fill_count", 32'h7);
        @(posedge clock); #1;
        act_q.push_back(32'(vc_a));
        @(negedge clock);
        idle_inputs();
        flush = 1'b1;
        we[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h55;
        re = 2'b11; raddr[0] = 5'd2; raddr[1] = 5'd9;
        expect_val("flush_same_rvalid", 32'h1);
        expect_val("flush_same_byp9", 32'h55);
        expect_val("flush_same_nobyp_rvalid9", 32'h0);
        #2;
        act_q.push_back(32'(rvalid_a[0]));
        act_q.push_back(32'(rdata_a[1]));
        act_q.push_back(32'(rvalid_b[1]));
        expect_val("flush_count", 32'h1);
        expect_val("flush_rvalid2", 32'h0);
        expect_val("flush_rdata2_kept", 32'h102);
        expect_val("flush_rdata9", 32'h55);
        expect_val("flush_rvalid9", 32'h1);
        expect_val("lat1_preflush_rvalid", 32'h1);
        @(posedge clock); #1;
        act_q.push_back(32'(vc_a));
        act_q.push_back(32'(rvalid_a[0]));
        act_q.push_back(32'(rdata_a[0]));
        act_q.push_back(32'(rdata_a[1]));
        act_q.push_back(32'(rvalid_a[1]));
        act_q.push_back(32'(rvalid_c[0]));
        @(negedge clock);
        idle_inputs();
        re = 2'b11; raddr[0] = 5'd2; raddr[1] = 5'd9;
        expect_val("lat1_flush_rvalid", 32'h0);
        expect_val("lat1_flush_rdata", 32'h102);
        expect_val("lat1_rdata9", 32'h55);
        expect_val("lat1_rvalid9", 32'h1);
        @(posedge clock); #1;
        act_q.push_back(32'(rvalid_c[0]));
        act_q.push_back(32'(rdata_c[0]));
        act_q.push_back(32'(rdata_c[1]));
        act_q.push_back(32'(rvalid_c[1]));
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            logic [31:0] a = (act_q.size() > 0) ? act_q.pop_front() : 32'hxxxx_xxxx;
            n_cmp++;
            if (a !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h required %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_latency1();
        @(negedge clock);
        idle_inputs();
        we[0] = 1'b1; waddr[0] = 5'd12; wdata[0] = 32'h77;
        re[0] = 1'b1; raddr[0] = 5'd12;
        expect_val("lat1_first_rdata", 32'h0);
        expect_val("lat1_first_rvalid", 32'h0);
        @(posedge clock); #1;
        act_q.push_back(32'(rdata_c[0]));
        act_q.push_back(32'(rvalid_c[0]));
        @(negedge clock);
        idle_inputs();
        re[0] = 1'b1; raddr[0] = 5'd12;
        expect_val("lat1_second_rdata", 32'h77);
        expect_val("lat1_second_rvalid", 32'h1);
        @(posedge clock); #1;
        act_q.push_back(32'(rdata_c[0]));
        act_q.push_back(32'(rvalid_c[0]));
        @(negedge clock);
        idle_inputs();
        expect_val("lat1_hold", 32'h77);
        expect_val("re_off_comb", 32'h0);
        #2;
        act_q.push_back(32'(rdata_c[0]));
        act_q.push_back(32'(rdata_b[0]));
        expect_val("lat1_re_off_rdata", 32'h0);
        expect_val("lat1_re_off_rvalid", 32'h0);
        @(posedge clock); #1;
        act_q.push_back(32'(rdata_c[0]));
        act_q.push_back(32'(rvalid_c[0]));
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            logic [31:0] a = (act_q.size() > 0) ? act_q.pop_front() : 32'hxxxx_xxxx;
            n_cmp++;
            if (a !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h required %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clock);
        idle_inputs();
        we = 2'b11; waddr[0] = 5'd30; waddr[1] = 5'd30;
        wdata[0] = 32'hFF; wdata[1] = 32'hEE;
        re[0] = 1'b1; raddr[0] = 5'd30;
        expect_val("oor_byp_rdata", 32'h0);
        expect_val("oor_byp_rvalid", 32'h0);
        expect_val("inrange_byp_rdata", 32'hEE);
        #2;
        act_q.push_back(32'(rdata_d[0]));
        act_q.push_back(32'(rvalid_d[0]));
        act_q.push_back(32'(rdata_a[0]));
        expect_val("oor_count", 32'h2);
        expect_val("oor_wconflict", 32'h0);
        expect_val("inrange_wconflict", 32'h1);
        expect_val("oor_rdata", 32'h0);
        expect_val("oor_rvalid", 32'h0);
        expect_val("oor_port1_rdata", 32'h0);
        expect_val("oor_port1_rvalid", 32'h0);
        @(posedge clock); #1;
        act_q.push_back(32'(vc_d));
        act_q.push_back(32'(wc_d));
        act_q.push_back(32'(wc_a));
        act_q.push_back(32'(rdata_d[0]));
        act_q.push_back(32'(rvalid_d[0]));
        act_q.push_back(32'(rdata_d[1]));
        act_q.push_back(32'(rvalid_d[1]));
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            logic [31:0] a = (act_q.size() > 0) ? act_q.pop_front() : 32'hxxxx_xxxx;
            n_cmp++;
            if (a !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h required %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        idle_inputs();
        we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'h5A;
        re[0] = 1'b1; raddr[0] = 5'd5;
        @(negedge clock);
        idle_inputs();
        re[0] = 1'b1; raddr[0] = 5'd5;
        expect_val("pre_reset_lat1", 32'h5A);
        expect_val("pre_reset_count", 32'h4);
        @(posedge clock); #1;
        act_q.push_back(32'(rdata_c[0]));
        act_q.push_back(32'(vc_a));
        #2;
        reset = 1'b1;
        expect_val("mid_reset_count", 32'h0);
        expect_val("mid_reset_lat1", 32'h0);
        expect_val("mid_reset_rdata", 32'h0);
        expect_val("mid_reset_rvalid", 32'h0);
        #1;
        act_q.push_back(32'(vc_a));
        act_q.push_back(32'(rdata_c[0]));
        act_q.push_back(32'(rdata_a[0]));
        act_q.push_back(32'(rvalid_a[0]));
        @(negedge clock);
        idle_inputs();
        flush = 1'b1;
        we[0] = 1'b1; waddr[0] = 5'd6; wdata[0] = 32'h66;
        @(negedge clock);
        reset = 1'b0;
        idle_inputs();
        re[0] = 1'b1; raddr[0] = 5'd6;
        expect_val("held_write_rdata", 32'h0);
        expect_val("held_write_rvalid", 32'h0);
        expect_val("held_write_count", 32'h0);
        #2;
        act_q.push_back(32'(rdata_a[0]));
        act_q.push_back(32'(rvalid_a[0]));
        act_q.push_back(32'(vc_a));
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            logic [31:0] a = (act_q.size() > 0) ? act_q.pop_front() : 32'hxxxx_xxxx;
            n_cmp++;
            if (a !== e.val) begin
                n_err++;
                $display("FAIL %s: observed %h required %h", e.name, a, e.val);
            end
        end
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_write_bypass();
        test_conflict();
        test_flush();
        test_latency1();
        test_out_of_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
